// File: rtl/regfile_pkg.sv
// Shared types, defaults and helpers for the multi-port register file.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package regfile_pkg;

   typedef enum logic {
      RF_IDLE  = 1'b0,
      RF_CLEAR = 1'b1
   } rf_state_e;

   localparam int RF_DEF_WIDTH = 8;
   localparam int RF_DEF_DEPTH = 8;

   // Address width for a given entry count
   function automatic int rf_aw(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Bulk-clear sequencer: walks entries 1..DEPTH-1 and zeroes one per cycle.
// Latency: busy rises the cycle after clr is sampled and lasts DEPTH-1 cycles.
// Backpressure: none; clr is ignored while the sweep runs (no restart).
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int DEPTH = RF_DEF_DEPTH,
   parameter int AW    = rf_aw(RF_DEF_DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   output logic          idle_o,
   output logic          busy_o,
   output logic          clr_we_o,
   output logic [AW-1:0] clr_addr_o
);

   rf_state_e     state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;

   // State and sweep-counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RF_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, counter and the zeroing write presented to the array
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      clr_we_o   = 1'b0;
      clr_addr_o = cnt_q;
      case (state_q)
         RF_IDLE: begin
            if (clr_i) begin
               state_d = RF_CLEAR;
               // Entry 0 is hard-wired to zero, so the sweep starts at 1
               cnt_d   = AW'(1);
            end
         end
         RF_CLEAR: begin
            clr_we_o = 1'b1;
            cnt_d    = cnt_q + AW'(1);
            if (cnt_q == AW'(DEPTH - 1)) begin
               state_d = RF_IDLE;
            end
         end
         default: state_d = RF_IDLE;
      endcase
   end

   assign busy_o = (state_q == RF_CLEAR);
   assign idle_o = (state_q == RF_IDLE);

endmodule

// File: rtl/regfile_multi.sv
// Two-read/one-write register file, entry 0 reads zero, bulk clear with busy flag.
// Latency: reads 0 cycles (READ_REG=0) or 1 cycle (READ_REG=1); writes visible after the edge.
// Backpressure: writes are silently dropped while busy or when clr is asserted. Build option: REGFILE_BYPASS_EN.
module regfile_multi
   import regfile_pkg::*;
#(
   parameter  int WIDTH    = RF_DEF_WIDTH,
   parameter  int DEPTH    = RF_DEF_DEPTH,
   parameter  int READ_REG = 0,
   localparam int AW       = rf_aw(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr_a,
   input  logic [AW-1:0]    raddr_b,
   input  logic             clr,
   output logic [WIDTH-1:0] rdata_a,
   output logic [WIDTH-1:0] rdata_b,
   output logic             busy
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   logic             idle;
   logic             clr_we;
   logic [AW-1:0]    clr_addr;
   logic             wr_acc;
   logic [WIDTH-1:0] rd_a;
   logic [WIDTH-1:0] rd_b;

   regfile_clear_seq #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_clear_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (clr),
      .idle_o     (idle),
      .busy_o     (busy),
      .clr_we_o   (clr_we),
      .clr_addr_o (clr_addr)
   );

   // A host write lands only when idle, not colliding with clr, and not to entry 0.
   // rst_n is included so forwarding cannot leak wdata onto the outputs during reset.
   assign wr_acc = rst_n && idle && we && !clr && (waddr != '0);

   // Next array contents: sweep zeroing and host writes are mutually exclusive
   always_comb begin
      mem_d = mem_q;
      if (clr_we) begin
         mem_d[clr_addr] = '0;
      end
      if (wr_acc) begin
         mem_d[waddr] = wdata;
      end
      mem_d[0] = '0;
   end

   // Storage array
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   // Read data ahead of the optional output register, with optional forwarding
   always_comb begin
      rd_a = (raddr_a == '0) ? '0 : mem_q[raddr_a];
      rd_b = (raddr_b == '0) ? '0 : mem_q[raddr_b];
`ifdef REGFILE_BYPASS_EN
      // wr_acc already excludes address 0 and every dropped write
      if (wr_acc && (waddr == raddr_a)) begin
         rd_a = wdata;
      end
      if (wr_acc && (waddr == raddr_b)) begin
         rd_b = wdata;
      end
`endif
   end

   if (READ_REG != 0) begin : g_rd_reg
      logic [WIDTH-1:0] rdata_a_q;
      logic [WIDTH-1:0] rdata_b_q;

      // Registered read ports sample pre-write array contents
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
         end else begin
            rdata_a_q <= rd_a;
            rdata_b_q <= rd_b;
         end
      end

      assign rdata_a = rdata_a_q;
      assign rdata_b = rdata_b_q;
   end else begin : g_rd_comb
      assign rdata_a = rd_a;
      assign rdata_b = rd_b;
   end

endmodule

// File: tb/tb_regfile_multi.sv
// Bench for regfile_multi: one combinational-read and one registered-read instance on shared inputs.
// Latency: checks comb outputs in the same cycle, registered outputs one cycle later.
// Backpressure: exercises dropped writes during clear and on clr/we collision.
module tb_regfile_multi;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       we;
   logic       clr;
   logic [2:0] waddr;
   logic [2:0] raddr_a;
   logic [2:0] raddr_b;
   logic [7:0] wdata;
   logic [7:0] ra0, rb0, ra1, rb1;
   logic       busy0, busy1;

   int checks   = 0;
   int failures = 0;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   always #5 clk = ~clk;

   regfile_multi #(.WIDTH(8), .DEPTH(8), .READ_REG(0)) dut_c (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .clr(clr),
      .rdata_a(ra0), .rdata_b(rb0), .busy(busy0)
   );

   regfile_multi #(.WIDTH(8), .DEPTH(8), .READ_REG(1)) dut_r (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .clr(clr),
      .rdata_a(ra1), .rdata_b(rb1), .busy(busy1)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      we    = 1'b1;
      waddr = a;
      wdata = d;
      tick();
      we    = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         we      = 1'($urandom_range(0, 1));
         clr     = 1'($urandom_range(0, 1));
         waddr   = 3'($urandom_range(0, 7));
         wdata   = 8'($urandom_range(0, 255));
         raddr_a = 3'($urandom_range(0, 7));
         raddr_b = 3'($urandom_range(0, 7));
         @(negedge clk);
         checks++;
         if ({ra0, rb0, ra1, rb1, busy0, busy1} !== 34'd0) begin
            failures++;
            $display("FAIL reset_outputs cyc=%0d got ra0=%h rb0=%h ra1=%h rb1=%h busy=%b%b expected all 0",
                     i, ra0, rb0, ra1, rb1, busy0, busy1);
         end
         tick();
      end
      // Release and try to write entry 0
      rst_n = 1'b1; clr = 1'b0; raddr_a = 3'd0; raddr_b = 3'd0;
      we = 1'b1; waddr = 3'd0; wdata = 8'hA5;
      @(negedge clk);
      checks++;
      if (ra0 !== 8'h00 || rb0 !== 8'h00) begin
         failures++;
         $display("FAIL zero_fwd got %h/%h expected 00/00", ra0, rb0);
      end
      tick();
      we = 1'b0;
      @(negedge clk);
      checks++;
      if (ra0 !== 8'h00 || busy0 !== 1'b0) begin
         failures++;
         $display("FAIL zero_comb got %h busy=%b expected 00 busy=0", ra0, busy0);
      end
      tick();
      @(negedge clk);
      checks++;
      if (ra1 !== 8'h00 || rb1 !== 8'h00) begin
         failures++;
         $display("FAIL zero_reg got %h/%h expected 00/00", ra1, rb1);
      end
      tick();
   endtask

   task automatic test_basic_rw;
      wr(3'd4, 8'h3C);
      wr(3'd7, 8'h81);
      raddr_a = 3'd4; raddr_b = 3'd7;
      @(negedge clk);
      checks++;
      if (ra0 !== 8'h3C || rb0 !== 8'h81) begin
         failures++;
         $display("FAIL rw_comb got %h/%h expected 3c/81", ra0, rb0);
      end
      checks++;
      if (ra1 !== 8'h00 || rb1 !== 8'h00) begin
         failures++;
         $display("FAIL rw_reg_latency got %h/%h expected 00/00", ra1, rb1);
      end
      tick();
      @(negedge clk);
      checks++;
      if (ra1 !== 8'h3C || rb1 !== 8'h81) begin
         failures++;
         $display("FAIL rw_reg got %h/%h expected 3c/81", ra1, rb1);
      end
      tick();
   endtask

   task automatic test_same_cycle;
      logic [7:0] exp_v;
      exp_v = BYP ? 8'h22 : 8'h11;
      wr(3'd5, 8'h11);
      raddr_a = 3'd5; raddr_b = 3'd5;
      we = 1'b1; waddr = 3'd5; wdata = 8'h22;
      @(negedge clk);
      checks++;
      if (ra0 !== exp_v || rb0 !== exp_v) begin
         failures++;
         $display("FAIL same_comb got %h/%h expected %h", ra0, rb0, exp_v);
      end
      tick();
      we = 1'b0;
      @(negedge clk);
      checks++;
      if (ra1 !== exp_v || rb1 !== exp_v || ra0 !== 8'h22) begin
         failures++;
         $display("FAIL same_reg got %h/%h comb %h expected %h/%h comb 22", ra1, rb1, ra0, exp_v, exp_v);
      end
      tick();
      @(negedge clk);
      checks++;
      if (ra1 !== 8'h22 || rb1 !== 8'h22) begin
         failures++;
         $display("FAIL same_reg_next got %h/%h expected 22/22", ra1, rb1);
      end
      tick();
   endtask

   task automatic test_bulk_clear;
      int n_busy;
      bit done;
      for (int a = 1; a < 8; a++) wr(3'(a), 8'hFF);
      raddr_a = 3'd7; raddr_b = 3'd3;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      n_busy = 0;
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         if (busy0) begin
            n_busy++;
            we = (n_busy == 5); waddr = 3'd3; wdata = 8'h77;
            clr = (n_busy == 4);
            @(negedge clk);
            checks++;
            if (ra0 !== 8'hFF) begin
               failures++;
               $display("FAIL clear_entry7 busy_cyc=%0d got %h expected ff", n_busy, ra0);
            end
            if (n_busy >= 4) begin
               checks++;
               if (rb0 !== 8'h00) begin
                  failures++;
                  $display("FAIL clear_entry3 busy_cyc=%0d got %h expected 00", n_busy, rb0);
               end
            end
            tick();
         end else begin
            done = 1'b1;
         end
      end
      we = 1'b0; clr = 1'b0;
      checks++;
      if (n_busy != 7) begin
         failures++;
         $display("FAIL clear_busy_len got %0d expected 7", n_busy);
      end
      @(negedge clk);
      checks++;
      if (ra0 !== 8'h00 || rb0 !== 8'h00) begin
         failures++;
         $display("FAIL clear_after_comb got %h/%h expected 00/00", ra0, rb0);
      end
      tick();
      @(negedge clk);
      checks++;
      if (ra1 !== 8'h00 || rb1 !== 8'h00) begin
         failures++;
         $display("FAIL clear_after_reg got %h/%h expected 00/00", ra1, rb1);
      end
      tick();
   endtask

   task automatic test_clr_with_we;
      int n_busy;
      bit done;
      raddr_a = 3'd2; raddr_b = 3'd2;
      clr = 1'b1; we = 1'b1; waddr = 3'd2; wdata = 8'h55;
      @(negedge clk);
      checks++;
      if (ra0 !== 8'h00) begin
         failures++;
         $display("FAIL clrwe_fwd got %h expected 00", ra0);
      end
      tick();
      clr = 1'b0; we = 1'b0;
      n_busy = 0;
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         if (busy0) begin
            n_busy++;
            tick();
         end else begin
            done = 1'b1;
         end
      end
      checks++;
      if (n_busy != 7) begin
         failures++;
         $display("FAIL clrwe_busy_len got %0d expected 7", n_busy);
      end
      @(negedge clk);
      checks++;
      if (ra0 !== 8'h00) begin
         failures++;
         $display("FAIL clrwe_comb got %h expected 00", ra0);
      end
      tick();
      @(negedge clk);
      checks++;
      if (ra1 !== 8'h00) begin
         failures++;
         $display("FAIL clrwe_reg got %h expected 00", ra1);
      end
      tick();
   endtask

   task automatic test_mid_clear_reset;
      wr(3'd6, 8'hC3);
      wr(3'd7, 8'hC3);
      raddr_a = 3'd7; raddr_b = 3'd6;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      tick();
      tick();
      checks++;
      if (busy0 !== 1'b1 || ra0 !== 8'hC3) begin
         failures++;
         $display("FAIL midrst_pre got busy=%b ra=%h expected busy=1 ra=c3", busy0, ra0);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy0, busy1, ra0, rb0, ra1, rb1} !== 34'd0) begin
         failures++;
         $display("FAIL midrst_async got busy=%b%b ra0=%h rb0=%h ra1=%h rb1=%h expected all 0",
                  busy0, busy1, ra0, rb0, ra1, rb1);
      end
      tick();
      rst_n = 1'b1;
      tick();
      wr(3'd6, 8'h9A);
      raddr_a = 3'd6; raddr_b = 3'd7;
      @(negedge clk);
      checks++;
      if (ra0 !== 8'h9A || rb0 !== 8'h00 || busy0 !== 1'b0) begin
         failures++;
         $display("FAIL midrst_write_comb got %h/%h busy=%b expected 9a/00 busy=0", ra0, rb0, busy0);
      end
      tick();
      @(negedge clk);
      checks++;
      if (ra1 !== 8'h9A || rb1 !== 8'h00) begin
         failures++;
         $display("FAIL midrst_write_reg got %h/%h expected 9a/00", ra1, rb1);
      end
      tick();
   endtask

   initial begin
      rst_n = 1'b0; we = 1'b0; clr = 1'b0;
      waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
      tick();
      test_reset();
      test_basic_rw();
      test_same_cycle();
      test_bulk_clear();
      test_clr_with_we();
      test_mid_clear_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "timeout");
   end

endmodule
